serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clock cycles per serial bit; legal range 1..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-005 SHALL have port data_in  input  8  frame payload, sampled on accept.
REQ-006 SHALL have port valid  input  1  upstream offers data_in.
REQ-007 SHALL have port ready  output  1  block can accept a payload this cycle.
REQ-008 SHALL have port serial_out  output  1  registered serial line, feeds the downstream shift chain's data input; idle level 1.
REQ-009 SHALL have port busy  output  1  high while a frame is in flight (START, DATA, STOP).
REQ-010 SHALL have port done  output  1  one-cycle pulse after a frame's stop bit completes.
REQ-011 SHALL have port frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-012 SHALL send 10-bit frames: start bit 0, data_in[0]..data_in[7] LSB first, stop bit 1; frame length equals the downstream 10-stage chain depth.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL assert ready only in IDLE with ena high; accept = valid & ready.
REQ-015 SHALL on accept latch data_in into an 8-bit shift register and enter START on the next edge; valid without ready is ignored, with no buffering.
REQ-016 SHALL hold each bit on serial_out for exactly CLKS_PER_BIT enabled cycles, timed by a bit-period counter reloaded at every bit boundary.
REQ-017 SHALL drive serial_out from a register: 0 in START, current LSB in DATA, 1 in STOP and IDLE.
REQ-018 SHALL transition START->DATA after one bit period, DATA->STOP after 8 bit periods (3-bit index 0..7), STOP->IDLE after one bit period.
REQ-019 SHALL pulse done for exactly one cycle, the first IDLE cycle after STOP, and increment frame_count in that same cycle; 255 wraps to 0.
REQ-020 SHALL permit accept in the done cycle; minimum accept-to-accept spacing is 10*CLKS_PER_BIT+1 cycles.
REQ-021 SHALL with ena low hold FSM state, bit counter, shift register, serial_out and frame_count, and drive ready and done low; operation resumes exactly where frozen.
REQ-022 SHALL keep busy = (state != IDLE), combinational from state.
REQ-023 SHALL with CLKS_PER_BIT=1 leave the full frame (stop bit in stage 1, start bit in stage 10) in a 10-stage chain clocked on the same edges at the done cycle.

Reset
REQ-024 SHALL on rst_n low at a rising edge force state IDLE, serial_out 1, bit counter 0, bit index 0, shift register 0x00, frame_count 0, done 0, regardless of ena.
REQ-025 SHALL abort any in-flight frame on mid-frame reset, without a done pulse and without a frame_count increment; ready is high on the first cycle after rst_n returns high (ena high).

Structure
REQ-026 SHALL place the FSM state encoding (2 bits), FRAME_BITS=10 and DATA_BITS=8 in shared package serial_frame_pkg.
REQ-027 SHALL implement the bit-period counter as sub-module bit_period_tick (inputs clk, rst_n, ena, reload; output tick), instantiated once.

Verification
REQ-028 Reset, then CLKS_PER_BIT=1, data_in=0xA5 accepted -> serial_out sequence 0,1,0,1,0,0,1,0,1,1 on 10 consecutive cycles; done 1 cycle later; frame_count=1.
REQ-029 CLKS_PER_BIT=4, data_in=0x3C -> each bit held 4 cycles, busy high 40 cycles, done at cycle 41 after accept.
REQ-030 valid held high with 0x01 then 0x80 back-to-back -> second accept in the done cycle of the first; frames separated by one idle 1 bit.
REQ-031 ena low for 5 cycles mid-DATA (bit 3 of 0xFF) -> serial_out frozen at 1; frame completes 5 cycles late and its bits are unchanged.
REQ-032 rst_n low during DATA of 0x00 -> serial_out 1 next edge, no done, frame_count unchanged, ready high after release.
REQ-033 256 frames of 0x55 -> frame_count wraps from 255 to 0 on the 256th done pulse.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and frame geometry for the serial frame transmitter.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // One start bit, the payload, one stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/bit_period_tick.sv
// Bit-period timer: tick marks the last enabled cycle of each bit period.
module bit_period_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic reload,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = ena && (cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (ena) begin
      cnt <= reload ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, stop bit.
// valid/ready: a payload transfers on a rising edge where valid and ready are both high.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] frame_count,
  output tx_state_t  state_dbg
);

  tx_state_t  state;
  logic [7:0] shift_q;
  logic [2:0] bit_idx;
  logic       serial_q;
  logic       done_q;
  logic [7:0] count_q;
  logic       tick;
  logic       reload;
  logic       accept;

  assign ready       = ena && (state == ST_IDLE);
  assign accept      = valid && ready;
  assign busy        = (state != ST_IDLE);
  // done_q survives a freeze, so it is masked while the block is disabled.
  assign done        = done_q && ena;
  assign serial_out  = serial_q;
  assign frame_count = count_q;
  assign state_dbg   = state;

  // Holding the timer at zero in IDLE makes the first START period full length.
  assign reload = (state == ST_IDLE) || tick;

  bit_period_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .reload(reload),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shift_q  <= 8'h00;
      bit_idx  <= 3'd0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else if (ena) begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_q  <= data_in;
            serial_q <= 1'b0;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            bit_idx  <= 3'd0;
            serial_q <= shift_q[0];
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              serial_q <= 1'b1;
              state    <= ST_STOP;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            done_q  <= 1'b1;
            count_q <= count_q + 8'd1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: one instance at 1 clock per bit, one at 4.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0] ena_v, valid_v, ready_v, so_v, busy_v, done_v;
  logic [7:0] data_v [2];
  logic [7:0] fc_v [2];
  tx_state_t  st_v [2];

  serial_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena_v[0]), .data_in(data_v[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .serial_out(so_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .frame_count(fc_v[0]), .state_dbg(st_v[0])
  );

  serial_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena_v[1]), .data_in(data_v[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .serial_out(so_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .frame_count(fc_v[1]), .state_dbg(st_v[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc [2];
  logic [9:0] exp_q[$];
  logic [9:0] chain;

  // cycle counter and a 10-stage chain fed by the 1-clock instance
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    chain <= {chain[8:0], so_v[0]};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] expand(input logic [9:0] f, input int k);
    logic [39:0] r = '0;
    for (int i = 0; i < 10 * k; i++) r[i] = f[i / k];
    return r;
  endfunction

  // scoreboard: collect enabled in-flight line samples, compare on done
  initial begin
    logic [39:0] cap [2];
    int          ns [2];
    logic [7:0]  exp_fc [2];
    logic [9:0]  e;
    int          k;
    for (int d = 0; d < 2; d++) begin
      cap[d] = '0; ns[d] = 0; exp_fc[d] = 8'd0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          ns[d] = 0; cap[d] = '0; exp_fc[d] = 8'd0;
        end else begin
          if (busy_v[d] && ena_v[d]) begin
            if (ns[d] < 40) cap[d][ns[d]] = so_v[d];
            ns[d]++;
          end
          if (done_v[d]) begin
            if (exp_q.size() == 0) begin
              check("spurious_done", done_v[d], 1'b0);
            end else begin
              e = exp_q.pop_front();
              k = (d == 0) ? 1 : 4;
              check("frame_len", ns[d], 10 * k);
              check("frame_bits", cap[d], expand(e, k));
              exp_fc[d] = exp_fc[d] + 8'd1;
              check("frame_count", fc_v[d], exp_fc[d]);
            end
            ns[d] = 0; cap[d] = '0;
          end
        end
      end
    end
  end

  // driver: offer a payload, wait for the accept edge; inputs change at posedge+1
  task automatic send(input int d, input logic [7:0] b, input bit keep, input bit push,
                      output logic done_seen, output logic line_seen);
    int t = 0;
    @(posedge clk); #1;
    valid_v[d] = 1'b1;
    data_v[d]  = b;
    @(negedge clk);
    while (!ready_v[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    done_seen = done_v[d];
    line_seen = so_v[d];
    if (!ready_v[d]) begin
      check("accept_timeout", ready_v[d], 1'b1);
      valid_v[d] = 1'b0;
      return;
    end
    if (push) exp_q.push_back({1'b1, b, 1'b0});
    @(posedge clk); #1;
    acc_cyc[d] = cyc;
    if (!keep) valid_v[d] = 1'b0;
  endtask

  // returns the cycle number (accept cycle = 0) of the done pulse
  task automatic wait_done(input int d, output int k);
    int t = 0;
    @(negedge clk);
    while (!done_v[d] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_v[d], 1'b1);
    k = cyc - acc_cyc[d] + 1;
  endtask

  initial begin
    logic       ds, ls, seen;
    int         k, a0, bc, dk;
    logic [9:0] seq, fr, ec;

    rst_n = 1'b0;
    ena_v = 2'b11;
    valid_v = 2'b00;
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_line", so_v[d], 1'b1);
      check("rst_busy", busy_v[d], 1'b0);
      check("rst_done", done_v[d], 1'b0);
      check("rst_count", fc_v[d], 8'd0);
      check("rst_state", st_v[d], ST_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready1", ready_v[0], 1'b1);
    check("rst_ready4", ready_v[1], 1'b1);

    // mid-frame reset during DATA of 0x00
    send(0, 8'h00, 1'b0, 1'b0, ds, ls);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("abort_busy", busy_v[0], 1'b1);
    check("abort_line_data", so_v[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_line", so_v[0], 1'b1);
    check("abort_busy_clr", busy_v[0], 1'b0);
    check("abort_done", done_v[0], 1'b0);
    check("abort_count", fc_v[0], 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", ready_v[0], 1'b1);
    seen = 1'b0;
    repeat (15) begin @(negedge clk); seen = seen | done_v[0]; end
    check("abort_no_done", seen, 1'b0);
    check("abort_count_after", fc_v[0], 8'd0);

    // 0xA5 at one clock per bit
    seq = 10'b1101001010;
    send(0, 8'hA5, 1'b0, 1'b1, ds, ls);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a5_line", so_v[0], seq[i]);
    end
    wait_done(0, k);
    check("a5_done_cycle", k, 11);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) ec[i] = fr[9 - i];
    check("a5_chain", chain, ec);
    check("a5_count", fc_v[0], 8'd1);

    // back-to-back with valid held high
    send(0, 8'h01, 1'b1, 1'b1, ds, ls);
    a0 = acc_cyc[0];
    send(0, 8'h80, 1'b0, 1'b1, ds, ls);
    check("b2b_accept_in_done", ds, 1'b1);
    check("b2b_idle_bit", ls, 1'b1);
    check("b2b_spacing", acc_cyc[0] - a0, 11);
    wait_done(0, k);
    check("b2b_done_cycle", k, 11);

    // freeze during bit 3 of 0xFF
    send(0, 8'hFF, 1'b0, 1'b1, ds, ls);
    repeat (4) begin @(posedge clk); #1; end
    ena_v[0] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("freeze_line", so_v[0], 1'b1);
      check("freeze_ready", ready_v[0], 1'b0);
      check("freeze_busy", busy_v[0], 1'b1);
    end
    @(posedge clk); #1;
    ena_v[0] = 1'b1;
    wait_done(0, k);
    check("freeze_done_cycle", k, 16);

    // 0x3C at four clocks per bit
    send(1, 8'h3C, 1'b0, 1'b1, ds, ls);
    bc = 0;
    dk = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (busy_v[1]) bc++;
      if (done_v[1] && dk == 0) dk = i;
    end
    check("c4_busy_cycles", bc, 40);
    check("c4_done_cycle", dk, 41);

    // 256 frames of 0x55 from a fresh count
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("wrap_start", fc_v[0], 8'd0);
    for (int i = 0; i < 256; i++) begin
      send(0, 8'h55, (i != 255), 1'b1, ds, ls);
      if (i == 255) check("wrap_pre", fc_v[0], 8'd255);
    end
    wait_done(0, k);
    check("wrap_count", fc_v[0], 8'd0);

    repeat (20) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
